// File: rtl/axis_256to512_pack_pkg.sv
// Shared constants and state encoding for the 256-to-512 AXI4-Stream packer.
package axis_256to512_pack_pkg;

  localparam int C_S_AXIS_DATA_WIDTH  = 256;
  localparam int C_M_AXIS_DATA_WIDTH  = 512;
  localparam int C_S_AXIS_TUSER_WIDTH = 128;
  localparam int C_M_AXIS_TUSER_WIDTH = 128;
  localparam int C_S_KEEP             = C_S_AXIS_DATA_WIDTH / 8;
  localparam int C_M_KEEP             = C_M_AXIS_DATA_WIDTH / 8;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

endpackage

// File: rtl/axis_256to512_pack_if.sv
// AXI4-Stream bundle used for both the 256-bit ingress side and the 512-bit packed side.
interface axis_256to512_pack_if
  import axis_256to512_pack_pkg::*;
#(
  parameter int DATA_W = C_S_AXIS_DATA_WIDTH,
  parameter int USER_W = C_S_AXIS_TUSER_WIDTH
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_256to512_pack.sv
// Packs pairs of 256-bit AXI4-Stream beats into 512-bit beats; an odd trailing
// beat of a packet is emitted alone in the low half with the upper keep cleared.
module axis_256to512_pack
  import axis_256to512_pack_pkg::*;
(
  input logic                  axis_aclk,
  input logic                  axis_reset,
  axis_256to512_pack_if.slave  s_axis,
  axis_256to512_pack_if.master m_axis
);

  pack_state_t                       state_r;
  pack_state_t                       state_nxt_s;

  logic [C_S_AXIS_DATA_WIDTH-1:0]    hold_data_r;
  logic [C_S_KEEP-1:0]               hold_keep_r;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   hold_user_r;

  logic [C_M_AXIS_DATA_WIDTH-1:0]    out_data_r;
  logic [C_M_KEEP-1:0]               out_keep_r;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   out_user_r;
  logic                              out_valid_r;
  logic                              out_last_r;

  logic [C_M_AXIS_DATA_WIDTH-1:0]    load_data_s;
  logic [C_M_KEEP-1:0]               load_keep_s;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   load_user_s;
  logic                              load_last_s;
  logic                              load_s;
  logic                              capture_s;
  logic                              ready_s;
  logic                              accept_s;

  // Ready only looks at the output register, so the input side never waits on tvalid.
  assign ready_s        = !out_valid_r || m_axis.tready;
  assign accept_s       = s_axis.tvalid && ready_s;
  assign s_axis.tready  = ready_s;

  assign m_axis.tdata   = out_data_r;
  assign m_axis.tkeep   = out_keep_r;
  assign m_axis.tuser   = out_user_r;
  assign m_axis.tvalid  = out_valid_r;
  assign m_axis.tlast   = out_last_r;

  // Next-state and output-load decode.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    capture_s   = 1'b0;
    load_data_s = {{C_S_AXIS_DATA_WIDTH{1'b0}}, s_axis.tdata};
    load_keep_s = {{C_S_KEEP{1'b0}}, s_axis.tkeep};
    load_user_s = s_axis.tuser;
    load_last_s = s_axis.tlast;
    case (state_r)
      EMPTY: begin
        if (accept_s && s_axis.tlast) begin
          load_s = 1'b1;
        end else if (accept_s) begin
          capture_s   = 1'b1;
          state_nxt_s = HALF;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      HALF: begin
        load_data_s = {s_axis.tdata, hold_data_r};
        load_keep_s = {s_axis.tkeep, hold_keep_r};
        load_user_s = hold_user_r;
        if (accept_s) begin
          load_s      = 1'b1;
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = HALF;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // State register.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Hold register for the earlier beat of a pair.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      hold_data_r <= {C_S_AXIS_DATA_WIDTH{1'b0}};
      hold_keep_r <= {C_S_KEEP{1'b0}};
      hold_user_r <= {C_S_AXIS_TUSER_WIDTH{1'b0}};
    end else if (capture_s) begin
      hold_data_r <= s_axis.tdata;
      hold_keep_r <= s_axis.tkeep;
      hold_user_r <= s_axis.tuser;
    end
  end

  // Output register; a load in the same cycle as a transfer keeps tvalid high.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      out_data_r  <= {C_M_AXIS_DATA_WIDTH{1'b0}};
      out_keep_r  <= {C_M_KEEP{1'b0}};
      out_user_r  <= {C_M_AXIS_TUSER_WIDTH{1'b0}};
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_data_r  <= load_data_s;
      out_keep_r  <= load_keep_s;
      out_user_r  <= load_user_s;
      out_last_r  <= load_last_s;
      out_valid_r <= 1'b1;
    end else if (m_axis.tready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_256to512_pack.sv
// Self-checking bench for axis_256to512_pack: directed vector table, streaming,
// randomized traffic against a pairing reference model, and reset corner cases.
module tb_axis_256to512_pack;
  import axis_256to512_pack_pkg::*;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic [127:0] u;
    logic         l;
  } obeat_t;

  typedef struct {
    logic         v;
    beat_t        b;
    logic         mr;
    logic         ev;
    logic         er;
    logic [511:0] ed;
    logic [63:0]  ek;
    logic [127:0] eu;
    logic         el;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_256to512_pack_if #(.DATA_W(C_S_AXIS_DATA_WIDTH), .USER_W(C_S_AXIS_TUSER_WIDTH)) s_if ();
  axis_256to512_pack_if #(.DATA_W(C_M_AXIS_DATA_WIDTH), .USER_W(C_M_AXIS_TUSER_WIDTH)) m_if ();

  axis_256to512_pack dut (
    .axis_aclk  (clk),
    .axis_reset (rst),
    .s_axis     (s_if),
    .m_axis     (m_if)
  );

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  logic   track = 1'b0;
  logic   cont = 1'b0;
  int     cont_stall = 0;
  logic   stall_prev = 1'b0;
  obeat_t stall_snap;
  beat_t  acc_q[$];
  obeat_t got_q[$];
  int     out_cyc_q[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mkb(input int id, input logic [31:0] k, input logic [127:0] u, input logic l);
    beat_t b;
    logic [31:0] w;
    w = 32'hA000_0000 + 32'(id);
    b.d = {8{w}};
    b.k = k;
    b.u = u;
    b.l = l;
    return b;
  endfunction

  function automatic beat_t rndb(input logic l);
    beat_t b;
    for (int j = 0; j < 8; j++) b.d[j*32 +: 32] = $urandom();
    for (int j = 0; j < 4; j++) b.u[j*32 +: 32] = $urandom();
    b.l = l;
    b.k = l ? $urandom() : 32'hFFFF_FFFF;
    return b;
  endfunction

  function automatic vec_t mkv(input logic v, input beat_t b, input logic mr, input logic ev, input logic er,
                               input logic [511:0] ed, input logic [63:0] ek, input logic [127:0] eu, input logic el);
    vec_t t;
    t.v = v; t.b = b; t.mr = mr; t.ev = ev; t.er = er;
    t.ed = ed; t.ek = ek; t.eu = eu; t.el = el;
    return t;
  endfunction

  // Applies one cycle of stimulus at a falling edge and returns at the next falling edge.
  task automatic drive(input logic v, input beat_t b, input logic mr, output logic acc);
    if (track && stall_prev) begin
      chk("stable_data", m_if.tdata, stall_snap.d);
      chk("stable_ctl", {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tuser}, {1'b1, stall_snap.l, stall_snap.k, stall_snap.u});
    end
    s_if.tvalid = v;
    s_if.tdata  = b.d;
    s_if.tkeep  = b.k;
    s_if.tuser  = b.u;
    s_if.tlast  = b.l;
    m_if.tready = mr;
    #1;
    acc = s_if.tvalid && s_if.tready;
    if (cont && !s_if.tready) cont_stall++;
    if (track) begin
      if (acc) acc_q.push_back(b);
      if (m_if.tvalid && m_if.tready) begin
        got_q.push_back('{d: m_if.tdata, k: m_if.tkeep, u: m_if.tuser, l: m_if.tlast});
        out_cyc_q.push_back(cyc);
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      stall_snap = '{d: m_if.tdata, k: m_if.tkeep, u: m_if.tuser, l: m_if.tlast};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    vec_t   tbl[15];
    beat_t  bA, bB, bC1, bC2, bC3, bD, bE1, bE2, bF1, bF2, bZ, b;
    obeat_t exp_q[$];
    obeat_t e;
    logic   acc;
    int     len, tries, i;
    logic [31:0] ones;

    ones = 32'hFFFF_FFFF;
    bA  = mkb(1, ones, 128'h11, 1'b0);
    bB  = mkb(2, 32'h0000_000F, 128'h22, 1'b1);
    bC1 = mkb(3, ones, 128'h33, 1'b0);
    bC2 = mkb(4, ones, 128'h34, 1'b0);
    bC3 = mkb(5, 32'h0000_00FF, 128'h35, 1'b1);
    bD  = mkb(6, 32'h0000_0001, 128'h55, 1'b1);
    bE1 = mkb(7, ones, 128'h66, 1'b0);
    bE2 = mkb(8, 32'h0000_0003, 128'h67, 1'b1);
    bF1 = mkb(9, ones, 128'h77, 1'b0);
    bF2 = mkb(10, ones, 128'h78, 1'b1);
    bZ  = '{d: 256'd0, k: 32'd0, u: 128'd0, l: 1'b0};

    tbl[0]  = mkv(1'b1, bA,  1'b1, 1'b0, 1'b1, 512'd0, 64'd0, 128'd0, 1'b0);
    tbl[1]  = mkv(1'b1, bB,  1'b1, 1'b1, 1'b1, {bB.d, bA.d}, 64'h0000_000F_FFFF_FFFF, 128'h11, 1'b1);
    tbl[2]  = mkv(1'b1, bC1, 1'b1, 1'b0, 1'b1, 512'd0, 64'd0, 128'd0, 1'b0);
    tbl[3]  = mkv(1'b1, bC2, 1'b1, 1'b1, 1'b1, {bC2.d, bC1.d}, {64{1'b1}}, 128'h33, 1'b0);
    tbl[4]  = mkv(1'b1, bC3, 1'b1, 1'b1, 1'b1, {256'd0, bC3.d}, 64'h0000_0000_0000_00FF, 128'h35, 1'b1);
    tbl[5]  = mkv(1'b1, bD,  1'b1, 1'b1, 1'b1, {256'd0, bD.d}, 64'h0000_0000_0000_0001, 128'h55, 1'b1);
    tbl[6]  = mkv(1'b1, bE1, 1'b1, 1'b0, 1'b1, 512'd0, 64'd0, 128'd0, 1'b0);
    tbl[7]  = mkv(1'b1, bE2, 1'b0, 1'b1, 1'b0, {bE2.d, bE1.d}, 64'h0000_0003_FFFF_FFFF, 128'h66, 1'b1);
    for (int r = 8; r < 12; r++) tbl[r] = mkv(1'b1, bF1, 1'b0, 1'b1, 1'b0, {bE2.d, bE1.d}, 64'h0000_0003_FFFF_FFFF, 128'h66, 1'b1);
    tbl[12] = mkv(1'b1, bF1, 1'b1, 1'b0, 1'b1, 512'd0, 64'd0, 128'd0, 1'b0);
    tbl[13] = mkv(1'b1, bF2, 1'b1, 1'b1, 1'b1, {bF2.d, bF1.d}, {64{1'b1}}, 128'h77, 1'b1);
    tbl[14] = mkv(1'b0, bZ,  1'b1, 1'b0, 1'b1, 512'd0, 64'd0, 128'd0, 1'b0);

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", m_if.tvalid, 1'b0);
    chk("reset_data", m_if.tdata, 512'd0);
    chk("reset_keep_user_last", {m_if.tkeep, m_if.tuser, m_if.tlast}, '0);
    chk("reset_sready", s_if.tready, 1'b1);
    rst = 1'b0;

    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].v, tbl[r].b, tbl[r].mr, acc);
      chk($sformatf("row%0d_valid", r), m_if.tvalid, tbl[r].ev);
      chk($sformatf("row%0d_sready", r), s_if.tready, tbl[r].er);
      if (tbl[r].ev) begin
        chk($sformatf("row%0d_data", r), m_if.tdata, tbl[r].ed);
        chk($sformatf("row%0d_keep", r), m_if.tkeep, tbl[r].ek);
        chk($sformatf("row%0d_user", r), m_if.tuser, tbl[r].eu);
        chk($sformatf("row%0d_last", r), m_if.tlast, tbl[r].el);
      end
    end

    // Continuous 8-beat packets at full rate.
    track = 1'b1;
    cont  = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 8; j++) drive(1'b1, rndb(j == 7), 1'b1, acc);
    end
    cont = 1'b0;
    for (int j = 0; j < 3; j++) drive(1'b0, bZ, 1'b1, acc);
    chk("stream_sready_high", 32'(cont_stall), 32'd0);
    chk("stream_out_count", 32'(out_cyc_q.size()), 32'd12);
    for (int j = 1; j < out_cyc_q.size(); j++)
      chk($sformatf("stream_gap%0d", j), 32'(out_cyc_q[j] - out_cyc_q[j-1]), 32'd2);

    // Randomized packets with gaps and backpressure.
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        b = rndb(j == len - 1);
        if ($urandom_range(0, 3) == 0) drive(1'b0, bZ, ($urandom_range(0, 9) < 7), acc);
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
          drive(1'b1, b, ($urandom_range(0, 9) < 7), acc);
          tries++;
        end
        if (!acc) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout packet=%0d beat=%0d", p, j);
        end
      end
    end
    for (int j = 0; j < 4; j++) drive(1'b0, bZ, 1'b1, acc);
    track = 1'b0;

    // Reference: walk the accepted stream, pairing beats unless the first of a pair ends its packet.
    i = 0;
    while (i < acc_q.size()) begin
      if (acc_q[i].l || i + 1 >= acc_q.size()) begin
        e = '{d: {256'd0, acc_q[i].d}, k: {32'd0, acc_q[i].k}, u: acc_q[i].u, l: acc_q[i].l};
        i += 1;
      end else begin
        e = '{d: {acc_q[i+1].d, acc_q[i].d}, k: {acc_q[i+1].k, acc_q[i].k}, u: acc_q[i].u, l: acc_q[i+1].l};
        i += 2;
      end
      exp_q.push_back(e);
    end
    chk("model_out_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      chk($sformatf("model_data%0d", j), got_q[j].d, exp_q[j].d);
      chk($sformatf("model_ctl%0d", j), {got_q[j].k, got_q[j].u, got_q[j].l}, {exp_q[j].k, exp_q[j].u, exp_q[j].l});
    end

    // Asynchronous reset with a pending output.
    drive(1'b1, mkb(20, 32'h1, 128'h99, 1'b1), 1'b0, acc);
    chk("arst_pre_valid", m_if.tvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", m_if.tvalid, 1'b0);
    chk("arst_data", m_if.tdata, 512'd0);
    chk("arst_keep_user_last", {m_if.tkeep, m_if.tuser, m_if.tlast}, '0);
    chk("arst_sready", s_if.tready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Reset while holding a half beat: the next packet must not pair with it.
    drive(1'b1, mkb(21, ones, 128'hAA, 1'b0), 1'b1, acc);
    chk("half_valid", m_if.tvalid, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, mkb(22, ones, 128'hBB, 1'b0), 1'b1, acc);
    chk("post_rst_first_valid", m_if.tvalid, 1'b0);
    drive(1'b1, mkb(23, 32'h0000_FFFF, 128'hCC, 1'b1), 1'b1, acc);
    chk("post_rst_valid", m_if.tvalid, 1'b1);
    chk("post_rst_data", m_if.tdata, {mkb(23, 32'h0, 128'h0, 1'b0).d, mkb(22, 32'h0, 128'h0, 1'b0).d});
    chk("post_rst_ctl", {m_if.tkeep, m_if.tuser, m_if.tlast}, {64'h0000_FFFF_FFFF_FFFF, 128'hBB, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
